// File: rtl/video_timing_out_pkg.sv
// Shared raster timing defaults, widths and flag bundle for the VDP pixel path.
// Imported by the timing/output stage and the reusable delay line.
package video_timing_out_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int COLOUR_W = 24;
    localparam int PIXEL_W  = 9;
    localparam int CNT_W    = 11;
    localparam int CMP_W    = 12;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_flags_t;

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_timing_out_delay_line.sv
// vdp_delay_line: DEPTH-stage register pipeline, DEPTH=0 is a plain wire.
// Ports: clk, rst (async active-low, loads RST_VAL), d_i in, q_o out.
module vdp_delay_line #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_out.sv
// Raster timing generator and blanked RGB888/sync output stage, 1 pixel/clk.
// Ports: clk, rst (async active-low), colour_in from palette; pixel_x/y,
// pixel_active, frame_start, line_start, vblank to renderer; vga_* to encoder.
module video_timing_out
    import video_timing_out_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   RENDER_LAT = 2,
    parameter int   PAL_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [CNT_W-1:0]    pixel_x,
    output logic [CNT_W-1:0]    pixel_y,
    output logic                pixel_active,
    output logic                frame_start,
    output logic                line_start,
    output logic                vblank,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAT     = RENDER_LAT + PAL_LAT;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
        $error("video_timing_out: H_TOTAL and V_TOTAL must be <= 2048");
    end

    // Comparisons use one spare bit so a boundary of exactly 2048 still fits.
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CMP_W-1:0] H_ACT  = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT  = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_BEG = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_BEG = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [CMP_W-1:0] h_x, v_x;

    sync_flags_t flags0, flags_dly;

    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_x = {1'b0, h_q};
    assign v_x = {1'b0, v_q};

    always_comb begin
        flags0.active = (h_x < H_ACT) && (v_x < V_ACT);
        flags0.hs     = (h_x >= HS_BEG) && (h_x < HS_END);
        flags0.vs     = (v_x >= VS_BEG) && (v_x < VS_END);
    end

    assign pixel_x      = h_q;
    assign pixel_y      = v_q;
    assign pixel_active = flags0.active;
    assign frame_start  = (h_q == '0) && (v_q == '0);
    assign line_start   = (h_q == '0);
    assign vblank       = (v_x >= V_ACT);

    // Flags wait for the renderer + palette so they meet their colour.
    vdp_delay_line #(
        .WIDTH   ($bits(sync_flags_t)),
        .DEPTH   (LAT),
        .RST_VAL ('0)
    ) u_flag_dly (
        .clk (clk),
        .rst (rst),
        .d_i (flags0),
        .q_o (flags_dly)
    );

    always_comb begin
        r_d  = flags_dly.active ? colour_in[23:16] : 8'h00;
        g_d  = flags_dly.active ? colour_in[15:8]  : 8'h00;
        b_d  = flags_dly.active ? colour_in[7:0]   : 8'h00;
        de_d = flags_dly.active;
        hs_d = sync_level(flags_dly.hs, SYNC_POL);
        vs_d = sync_level(flags_dly.vs, SYNC_POL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= 8'h00;
            g_q  <= 8'h00;
            b_q  <= 8'h00;
            de_q <= 1'b0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign vga_r  = r_q;
    assign vga_g  = g_q;
    assign vga_b  = b_q;
    assign vga_de = de_q;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule

// File: tb/tb_video_timing_out.sv
// Self-checking bench: three video_timing_out instances (small, small
// with positive sync and short latency, default 640x480) vs a position model.
module tb_video_timing_out;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] colour = '0;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [23:0] col [0:3999];

    // A: small timing, default polarity and latency
    logic [10:0] a_px, a_py;
    logic        a_pa, a_fs, a_ls, a_vb, a_hs, a_vs, a_de;
    logic [7:0]  a_r, a_g, a_b;
    // B: small timing, SYNC_POL=1, RENDER_LAT=0
    logic [10:0] b_px, b_py;
    logic        b_pa, b_fs, b_ls, b_vb, b_hs, b_vs, b_de;
    logic [7:0]  b_r, b_g, b_b;
    // C: all defaults
    logic [10:0] c_px, c_py;
    logic        c_pa, c_fs, c_ls, c_vb, c_hs, c_vs, c_de;
    logic [7:0]  c_r, c_g, c_b;

    video_timing_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_a (
        .clk(clk), .rst(rst), .colour_in(colour),
        .pixel_x(a_px), .pixel_y(a_py), .pixel_active(a_pa),
        .frame_start(a_fs), .line_start(a_ls), .vblank(a_vb),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de)
    );

    video_timing_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .RENDER_LAT(0), .PAL_LAT(1)
    ) u_b (
        .clk(clk), .rst(rst), .colour_in(colour),
        .pixel_x(b_px), .pixel_y(b_py), .pixel_active(b_pa),
        .frame_start(b_fs), .line_start(b_ls), .vblank(b_vb),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de)
    );

    video_timing_out u_c (
        .clk(clk), .rst(rst), .colour_in(colour),
        .pixel_x(c_px), .pixel_y(c_py), .pixel_active(c_pa),
        .frame_start(c_fs), .line_start(c_ls), .vblank(c_vb),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
        .vga_hs(c_hs), .vga_vs(c_vs), .vga_de(c_de)
    );

    typedef struct {
        int  px, py;
        bit  pa, fs, ls, vb;
        int  rgb;
        bit  de, hs, vs;
    } exp_t;

    typedef struct {
        int cyc;
        int px, py;
        bit fs, ls, vb, de, hs, vs;
    } vec_t;

    vec_t vecs [10];

    // Expected view of cycle m after reset release, from raster arithmetic.
    function automatic exp_t model(input int m,
                                   input int ha, input int hfp,
                                   input int hsy, input int hbp,
                                   input int va, input int vfp,
                                   input int vsy, input int vbp,
                                   input int lat, input bit pol);
        exp_t e;
        int ht, vt, p, h, v;
        bit act, hsa, vsa;
        ht = ha + hfp + hsy + hbp;
        vt = va + vfp + vsy + vbp;
        e.px = m % ht;
        e.py = (m / ht) % vt;
        e.pa = (e.px < ha) && (e.py < va);
        e.fs = (e.px == 0) && (e.py == 0);
        e.ls = (e.px == 0);
        e.vb = (e.py >= va);
        p = m - lat - 1;
        if (p < 0) begin
            e.de  = 1'b0;
            e.rgb = 0;
            e.hs  = ~pol;
            e.vs  = ~pol;
        end else begin
            h   = p % ht;
            v   = (p / ht) % vt;
            act = (h < ha) && (v < va);
            hsa = (h >= ha + hfp) && (h < ha + hfp + hsy);
            vsa = (v >= va + vfp) && (v < va + vfp + vsy);
            e.de  = act;
            e.rgb = act ? int'(col[m-1]) : 0;
            e.hs  = hsa ? pol : ~pol;
            e.vs  = vsa ? pol : ~pol;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input string t, input int m, input exp_t e,
                           input logic [10:0] px, input logic [10:0] py,
                           input logic pa, input logic fs,
                           input logic ls, input logic vb,
                           input logic [23:0] rgb, input logic de,
                           input logic hs, input logic vs);
        string s;
        s = $sformatf("%s@%0d", t, m);
        chk({s, ".px"},  32'(px),  32'(e.px));
        chk({s, ".py"},  32'(py),  32'(e.py));
        chk({s, ".pa"},  32'(pa),  32'(e.pa));
        chk({s, ".fs"},  32'(fs),  32'(e.fs));
        chk({s, ".ls"},  32'(ls),  32'(e.ls));
        chk({s, ".vb"},  32'(vb),  32'(e.vb));
        chk({s, ".rgb"}, 32'(rgb), 32'(e.rgb));
        chk({s, ".de"},  32'(de),  32'(e.de));
        chk({s, ".hs"},  32'(hs),  32'(e.hs));
        chk({s, ".vs"},  32'(vs),  32'(e.vs));
    endtask

    task automatic check_all(input int m);
        exp_t e;
        e = model(m, 8, 2, 2, 2, 4, 1, 1, 1, 3, 1'b0);
        chk_dut("A", m, e, a_px, a_py, a_pa, a_fs, a_ls, a_vb,
                {a_r, a_g, a_b}, a_de, a_hs, a_vs);
        e = model(m, 8, 2, 2, 2, 4, 1, 1, 1, 1, 1'b1);
        chk_dut("B", m, e, b_px, b_py, b_pa, b_fs, b_ls, b_vb,
                {b_r, b_g, b_b}, b_de, b_hs, b_vs);
        e = model(m, 640, 16, 96, 48, 480, 10, 2, 33, 3, 1'b0);
        chk_dut("C", m, e, c_px, c_py, c_pa, c_fs, c_ls, c_vb,
                {c_r, c_g, c_b}, c_de, c_hs, c_vs);
    endtask

    // Called just after reset release; cycle 0 is the span before the
    // first rising edge.
    task automatic run_phase(input int n, input bit use_vecs);
        for (int m = 0; m < n; m++) begin
            if (m > 0) begin
                @(posedge clk);
                #1;
            end
            check_all(m);
            if (use_vecs) begin
                for (int i = 0; i < 10; i++) begin
                    if (vecs[i].cyc == m) begin
                        chk($sformatf("vecA@%0d", m),
                            {a_px, a_py, a_fs, a_ls, a_vb, a_de, a_hs, a_vs},
                            {11'(vecs[i].px), 11'(vecs[i].py),
                             vecs[i].fs, vecs[i].ls, vecs[i].vb,
                             vecs[i].de, vecs[i].hs, vecs[i].vs});
                    end
                end
            end
            col[m] = 24'($urandom);
            colour = col[m];
        end
    endtask

    initial begin
        exp_t e;
        bit   found;
        int   m;

        vecs[0] = '{0,   0,  0, 1, 1, 0, 0, 1, 1};
        vecs[1] = '{4,   4,  0, 0, 0, 0, 1, 1, 1};
        vecs[2] = '{13,  13, 0, 0, 0, 0, 0, 1, 1};
        vecs[3] = '{14,  0,  1, 0, 1, 0, 0, 0, 1};
        vecs[4] = '{15,  1,  1, 0, 0, 0, 0, 0, 1};
        vecs[5] = '{16,  2,  1, 0, 0, 0, 0, 1, 1};
        vecs[6] = '{56,  0,  4, 0, 1, 1, 0, 0, 1};
        vecs[7] = '{74,  4,  5, 0, 0, 1, 0, 1, 0};
        vecs[8] = '{98,  0,  0, 1, 1, 0, 0, 0, 1};
        vecs[9] = '{102, 4,  0, 0, 0, 0, 1, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_phase(2500, 1'b1);

        // Advance until A is showing a visible pixel, then yank reset.
        found = 1'b0;
        m = 2500;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            e = model(m, 8, 2, 2, 2, 4, 1, 1, 1, 3, 1'b0);
            if (e.de && e.rgb != 0) found = 1'b1;
            col[m] = 24'($urandom) | 24'h1;
            colour = col[m];
            m++;
        end
        chk("async.found", 32'(found), 32'd1);
        chk("async.pre_de", 32'(a_de), 32'(found));
        #2;
        rst = 1'b0;
        #1;
        chk("async.a_de",  32'(a_de), 32'd0);
        chk("async.a_rgb", 32'({a_r, a_g, a_b}), 32'd0);
        chk("async.a_hs",  32'(a_hs), 32'd1);
        chk("async.b_hs",  32'(b_hs), 32'd0);
        chk("async.b_vs",  32'(b_vs), 32'd0);
        chk("async.c_px",  32'(c_px), 32'd0);
        chk("async.a_py",  32'(a_py), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        run_phase(300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
